mii_rx_deframer: RTL and testbench

MII receive deframer between the PHY nibble interface and the framing block's receive buffer. Detects preamble/SFD, assembles nibbles into bytes and 64-bit words, and writes them into a dual-port RX buffer. It checks the CRC-32 FCS, reports the frame length, and holds a sticky receive-done flag until software acknowledges the frame. Runt, oversize, errored and overrun frames are dropped and counted.

---
 rtl/mii_rx_deframer.sv | 213 +++++++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into 64-bit buffer words,
// checks the CRC-32 residue and reports frame length; bad frames are dropped and counted.
module mii_rx_deframer #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic              clk_mii,
  input  logic              reset,
  input  logic              i_erx_dv,
  input  logic [3:0]        i_erxd,
  input  logic              i_erx_er,
  output logic              buf_we,
  output logic [ADDR_W-4:0] buf_addr,
  output logic [63:0]       buf_wdata,
  output logic [7:0]        buf_be,
  output logic              recv_done,
  output logic [ADDR_W:0]   recv_len,
  output logic              fcs_ok,
  input  logic              rx_ack,
  output logic [15:0]       drop_cnt
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StDrop  = 3'd5;

  localparam logic [31:0]   CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0]   CrcResidue = 32'hDEBB_20E3;
  localparam logic [ADDR_W:0] MinLen   = (ADDR_W + 1)'(MIN_LEN);
  localparam logic [ADDR_W:0] FcsLen   = (ADDR_W + 1)'(4);

  logic [2:0]        state_q, state_d;
  logic              dv_q;
  logic              phase_q, phase_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic              we_q, we_d;
  logic [ADDR_W-4:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        be_q, be_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              fcs_ok_q, fcs_ok_d;
  logic [15:0]       drop_q, drop_d;
  logic              drop_inc;
  logic              dv_rise;

  // Reflected CRC-32, LSB first, one nibble per call.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'd0, n};
    for (int i = 0; i < 4; i++) begin
      r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
    end
    return r;
  endfunction

  assign dv_rise = i_erx_dv & ~dv_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lo_nib_d   = lo_nib_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    done_d     = done_q;
    len_d      = len_q;
    fcs_ok_d   = fcs_ok_q;
    drop_inc   = 1'b0;

    case (state_q)
      StIdle: begin
        if (dv_rise) begin
          if (i_erxd == 4'h5) begin
            state_d = StPre;
          end else begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end
        end
      end
      StPre: begin
        if (!i_erx_dv) begin
          state_d = StIdle;
        end else if (i_erx_er) begin
          state_d = StDrop;
        end else if (i_erxd == 4'hD) begin
          state_d    = StData;
          byte_cnt_d = '0;
          phase_d    = 1'b0;
          crc_d      = 32'hFFFF_FFFF;
        end else if (i_erxd != 4'h5) begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!i_erx_dv) begin
          if (phase_q || (byte_cnt_q < MinLen)) begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end else begin
            state_d = StFlush;
            // Partial tail word goes out in the FLUSH cycle.
            if (byte_cnt_q[2:0] != 3'd0) begin
              we_d   = 1'b1;
              addr_d = byte_cnt_q[ADDR_W-1:3];
              be_d   = (8'd1 << byte_cnt_q[2:0]) - 8'd1;
            end
          end
        end else if (i_erx_er) begin
          state_d  = StDrop;
          drop_inc = 1'b1;
        end else begin
          crc_d   = crc_nib(crc_q, i_erxd);
          phase_d = ~phase_q;
          if (!phase_q) begin
            lo_nib_d = i_erxd;
          end else begin
            wdata_d[{byte_cnt_q[2:0], 3'b000} +: 8] = {i_erxd, lo_nib_q};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q[2:0] == 3'd7) begin
              we_d   = 1'b1;
              addr_d = byte_cnt_q[ADDR_W-1:3];
              be_d   = 8'hFF;
            end
            // Buffer full: the last word still lands, then the frame is abandoned.
            if (byte_cnt_d[ADDR_W]) begin
              state_d  = StDrop;
              drop_inc = 1'b1;
            end
          end
        end
      end
      StFlush: begin
        state_d  = StDone;
        done_d   = 1'b1;
        len_d    = byte_cnt_q - FcsLen;
        fcs_ok_d = (crc_q == CrcResidue);
      end
      StDone: begin
        if (dv_rise) begin
          drop_inc = 1'b1;
        end
        if (rx_ack) begin
          state_d  = StIdle;
          done_d   = 1'b0;
          len_d    = '0;
          fcs_ok_d = 1'b0;
        end
      end
      StDrop: begin
        if (!i_erx_dv) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

  always_ff @(posedge clk_mii) begin
    if (reset) begin
      state_q    <= StIdle;
      dv_q       <= 1'b1;
      phase_q    <= 1'b0;
      lo_nib_q   <= 4'd0;
      byte_cnt_q <= '0;
      crc_q      <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 64'd0;
      be_q       <= 8'd0;
      done_q     <= 1'b0;
      len_q      <= '0;
      fcs_ok_q   <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      dv_q       <= i_erx_dv;
      phase_q    <= phase_d;
      lo_nib_q   <= lo_nib_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      done_q     <= done_d;
      len_q      <= len_d;
      fcs_ok_q   <= fcs_ok_d;
      drop_q     <= drop_d;
    end
  end

  assign buf_we    = we_q;
  assign buf_addr  = addr_q;
  assign buf_wdata = wdata_q;
  assign buf_be    = be_q;
  assign recv_done = done_q;
  assign recv_len  = len_q;
  assign fcs_ok    = fcs_ok_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Scoreboard bench for mii_rx_deframer: stimulus queues expected buffer writes and
// frame completions; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mii_rx_deframer;

  localparam int ADDR_W = 11;

  logic              clk_mii = 1'b0;
  logic              reset;
  logic              i_erx_dv;
  logic [3:0]        i_erxd;
  logic              i_erx_er;
  logic              buf_we;
  logic [ADDR_W-4:0] buf_addr;
  logic [63:0]       buf_wdata;
  logic [7:0]        buf_be;
  logic              recv_done;
  logic [ADDR_W:0]   recv_len;
  logic              fcs_ok;
  logic              rx_ack;
  logic [15:0]       drop_cnt;

  mii_rx_deframer #(.ADDR_W(ADDR_W), .MIN_LEN(64)) dut (
    .clk_mii  (clk_mii),
    .reset    (reset),
    .i_erx_dv (i_erx_dv),
    .i_erxd   (i_erxd),
    .i_erx_er (i_erx_er),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_wdata(buf_wdata),
    .buf_be   (buf_be),
    .recv_done(recv_done),
    .recv_len (recv_len),
    .fcs_ok   (fcs_ok),
    .rx_ack   (rx_ack),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_mii = ~clk_mii;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  typedef struct {
    int   len;
    logic ok;
  } done_t;

  wr_t   wq[$];
  done_t dq[$];

  logic [7:0] frm [0:2199];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  int end_cyc = 0;
  int exp_drop = 0;
  logic done_prev = 1'b0;

  always @(posedge clk_mii) cyc++;

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Monitor
  always @(negedge clk_mii) begin
    wr_t e;
    done_t d;
    logic [63:0] m;
    if (buf_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d be=%h, required no write", buf_addr, buf_be);
      end else begin
        e = wq.pop_front();
        m = be_mask(e.be);
        if (buf_addr !== e.addr || buf_be !== e.be || (buf_wdata & m) !== (e.data & m)) begin
          errors++;
          $display("FAIL write_word: got addr=%0d be=%h data=%h, required addr=%0d be=%h data=%h",
                   buf_addr, buf_be, buf_wdata & m, e.addr, e.be, e.data & m);
        end
      end
      last_we_cyc = cyc;
    end
    if (recv_done === 1'b1 && !done_prev) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got recv_done=1 len=%0d, required no completion", recv_len);
      end else begin
        d = dq.pop_front();
        if (int'(recv_len) != d.len || fcs_ok !== d.ok) begin
          errors++;
          $display("FAIL done_info: got len=%0d fcs_ok=%b, required len=%0d fcs_ok=%b",
                   recv_len, fcs_ok, d.len, d.ok);
        end
      end
      done_rise_cyc = cyc;
    end
    done_prev = (recv_done === 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC-32 over frm[0..n-1], final inversion applied.
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int len, input int seed, input bit add_fcs, input bit flip);
    logic [31:0] f;
    for (int i = 0; i < 2200; i++) frm[i] = 8'((i * 37 + seed * 11 + 5) & 8'hFF);
    if (add_fcs) begin
      f = crc32(len);
      for (int j = 0; j < 4; j++) frm[len + j] = f[8*j +: 8];
      if (flip) frm[len + 1] = frm[len + 1] ^ 8'h10;
    end
  endtask

  task automatic push_words(input int nfull, input int part);
    wr_t e;
    for (int w = 0; w <= nfull; w++) begin
      if (w < nfull || part > 0) begin
        e.addr = 8'(w);
        for (int k = 0; k < 8; k++) e.data[8*k +: 8] = frm[8*w + k];
        e.be = (w < nfull) ? 8'hFF : 8'((1 << part) - 1);
        wq.push_back(e);
      end
    end
  endtask

  task automatic push_done(input int len, input logic ok);
    done_t d;
    d.len = len;
    d.ok  = ok;
    dq.push_back(d);
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    i_erx_dv = dv;
    i_erxd   = d;
    i_erx_er = er;
    @(posedge clk_mii);
    #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_buf_we", 64'(buf_we), 64'd0);
    chk("rst_buf_addr", 64'(buf_addr), 64'd0);
    chk("rst_buf_wdata", buf_wdata, 64'd0);
    chk("rst_buf_be", 64'(buf_be), 64'd0);
    chk("rst_recv_done", 64'(recv_done), 64'd0);
    chk("rst_recv_len", 64'(recv_len), 64'd0);
    chk("rst_fcs_ok", 64'(fcs_ok), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
  endtask

  task automatic send_frame(input int len, input int er_byte, input bit extra_nib,
                            input int rst_byte);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == rst_byte) begin
        reset = 1'b1;
        drive(1'b1, frm[i][3:0], 1'b0);
        reset = 1'b0;
        check_reset_outs();
      end else begin
        drive(1'b1, frm[i][3:0], (i == er_byte));
      end
      drive(1'b1, frm[i][7:4], 1'b0);
    end
    if (extra_nib) drive(1'b1, 4'hA, 1'b0);
    end_cyc = cyc;
    repeat (5) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    rx_ack = 1'b0;
    chk("ack_clears_done", 64'(recv_done), 64'd0);
    chk("ack_clears_len", 64'(recv_len), 64'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required run completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; i_erx_dv = 1'b0; i_erxd = 4'h0; i_erx_er = 1'b0; rx_ack = 1'b0;
    repeat (3) @(posedge clk_mii);
    #1;
    check_reset_outs();
    reset = 1'b0;
    repeat (2) drive(1'b0, 4'h0, 1'b0);

    // 60 payload + FCS
    build(60, 1, 1'b1, 1'b0);
    push_words(8, 0);
    push_done(60, 1'b1);
    send_frame(64, -1, 1'b0, -1);
    chk("f64_done", 64'(recv_done), 64'd1);
    chk("f64_drop", 64'(drop_cnt), 64'(exp_drop));
    ack();

    // 63 payload + FCS: partial tail word
    build(63, 2, 1'b1, 1'b0);
    push_words(8, 3);
    push_done(63, 1'b1);
    send_frame(67, -1, 1'b0, -1);
    chk("f67_flush_cycle", 64'(last_we_cyc), 64'(end_cyc + 1));
    chk("f67_done_cycle", 64'(done_rise_cyc), 64'(end_cyc + 2));
    ack();

    // Corrupted FCS still completes
    build(60, 3, 1'b1, 1'b1);
    push_words(8, 0);
    push_done(60, 1'b0);
    send_frame(64, -1, 1'b0, -1);
    chk("badfcs_done", 64'(recv_done), 64'd1);
    ack();

    // Receive error at byte 20
    build(60, 4, 1'b1, 1'b0);
    push_words(2, 0);
    send_frame(64, 20, 1'b0, -1);
    exp_drop++;
    chk("er_no_done", 64'(recv_done), 64'd0);
    chk("er_drop", 64'(drop_cnt), 64'(exp_drop));

    // Good frame, then an overrun frame before ack
    build(60, 5, 1'b1, 1'b0);
    push_words(8, 0);
    push_done(60, 1'b1);
    send_frame(64, -1, 1'b0, -1);
    build(60, 6, 1'b1, 1'b0);
    send_frame(64, -1, 1'b0, -1);
    exp_drop++;
    chk("overrun_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("overrun_hold_done", 64'(recv_done), 64'd1);
    chk("overrun_hold_len", 64'(recv_len), 64'd60);
    ack();
    build(60, 7, 1'b1, 1'b0);
    push_words(8, 0);
    push_done(60, 1'b1);
    send_frame(64, -1, 1'b0, -1);
    chk("third_done", 64'(recv_done), 64'd1);
    ack();

    // Runt
    build(40, 8, 1'b0, 1'b0);
    push_words(5, 0);
    send_frame(40, -1, 1'b0, -1);
    exp_drop++;
    chk("runt_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("runt_no_done", 64'(recv_done), 64'd0);

    // Oversize: writes stop at word 255
    build(2100, 9, 1'b0, 1'b0);
    push_words(256, 0);
    send_frame(2100, -1, 1'b0, -1);
    exp_drop++;
    chk("oversize_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("oversize_no_done", 64'(recv_done), 64'd0);

    // Dribble nibble
    build(60, 10, 1'b1, 1'b0);
    push_words(8, 0);
    send_frame(64, -1, 1'b1, -1);
    exp_drop++;
    chk("odd_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("odd_no_done", 64'(recv_done), 64'd0);

    // Reset at byte 30 with dv held high
    build(60, 11, 1'b1, 1'b0);
    push_words(3, 0);
    send_frame(64, -1, 1'b0, 30);
    exp_drop = 0;
    chk("postrst_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("postrst_no_done", 64'(recv_done), 64'd0);
    build(60, 12, 1'b1, 1'b0);
    push_words(8, 0);
    push_done(60, 1'b1);
    send_frame(64, -1, 1'b0, -1);
    chk("postrst_done", 64'(recv_done), 64'd1);
    ack();

    repeat (3) drive(1'b0, 4'h0, 1'b0);
    chk("writes_left", 64'(wq.size()), 64'd0);
    chk("dones_left", 64'(dq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
